clkgen_frac: RTL and testbench



---
 rtl/clkgen_pkg.sv | 19 +
 rtl/clkgen_chan.sv | 84 ++++++++
 rtl/clkgen_frac.sv | 40 ++++
 tb/tb_clkgen_frac.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clkgen_pkg.sv
// Shared constants for the fractional clock-enable generator: debt limit helper
// and the default freq/fref ratios used by the board timing channels.
package clkgen_pkg;

  function automatic int max_debt(input int debt_w);
    return (1 << debt_w) - 1;
  endfunction

  // CPU 3.5 MHz from a 25 MHz clock
  localparam int CPU_FREQ  = 35;
  localparam int CPU_FREF  = 250;
  // AY 1.75 MHz from the same clock
  localparam int AY_FREQ   = 7;
  localparam int AY_FREF   = 100;
  // tape sampling at 44.1 kHz against the 3.5 MHz CPU rate
  localparam int TAPE_FREQ = 441;
  localparam int TAPE_FREF = 35000;

endpackage

// File: rtl/clkgen_chan.sv
// One fractional enable channel: Bresenham accumulator, deferred-tick debt with
// one-pulse-per-cycle catch-up, and a sticky flag for ticks lost on saturation.
module clkgen_chan
  import clkgen_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DEBT_W = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              active,
  input  logic [WIDTH-1:0]  freq,
  input  logic [WIDTH-1:0]  fref,
  input  logic              wait_req,
  input  logic              clr_lost,
  output logic              hold,
  output logic [DEBT_W-1:0] debt,
  output logic              lost
);

  localparam logic [DEBT_W-1:0] DEBT_MAX = DEBT_W'(max_debt(DEBT_W));

  logic [WIDTH-1:0]  acc;
  logic [WIDTH-1:0]  acc_next;
  logic [WIDTH:0]    sum;
  logic              tick;
  logic              issue;
  logic              lost_set;
  logic [DEBT_W-1:0] debt_next;

  always_comb begin
    sum      = {1'b0, acc} + {1'b0, freq};
    tick     = 1'b0;
    acc_next = acc;
    if (fref == '0 || freq == '0) begin
      acc_next = '0;
    end else if (acc >= fref) begin
      // ratio was reprogrammed below the current phase: restart silently
      acc_next = '0;
    end else if (freq >= fref) begin
      tick     = 1'b1;
      acc_next = '0;
    end else if (sum >= {1'b0, fref}) begin
      tick     = 1'b1;
      acc_next = WIDTH'(sum - {1'b0, fref});
    end else begin
      acc_next = sum[WIDTH-1:0];
    end
  end

  always_comb begin
    issue     = ~wait_req & (tick | (debt != '0));
    debt_next = debt;
    lost_set  = 1'b0;
    if (tick && !issue) begin
      if (debt == DEBT_MAX) lost_set  = 1'b1;
      else                  debt_next = debt + 1'b1;
    end else if (!tick && issue) begin
      debt_next = debt - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      acc  <= '0;
      debt <= '0;
      hold <= 1'b0;
      lost <= 1'b0;
    end else if (!active) begin
      acc  <= '0;
      debt <= '0;
      hold <= 1'b0;
      if (clr_lost) lost <= 1'b0;
    end else begin
      acc  <= acc_next;
      debt <= debt_next;
      hold <= issue;
      // a drop in the same cycle as a clear must stay visible
      if (lost_set)      lost <= 1'b1;
      else if (clr_lost) lost <= 1'b0;
    end
  end

endmodule

// File: rtl/clkgen_frac.sv
// N-channel fractional clock-enable generator; each channel is an independent
// clkgen_chan, this level only unpacks the per-channel buses.
module clkgen_frac
  import clkgen_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 16,
  parameter int DEBT_W   = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [CHANNELS-1:0]        active,
  input  logic [CHANNELS*WIDTH-1:0]  freq,
  input  logic [CHANNELS*WIDTH-1:0]  fref,
  input  logic [CHANNELS-1:0]        wait_req,
  input  logic [CHANNELS-1:0]        clr_lost,
  output logic [CHANNELS-1:0]        hold,
  output logic [CHANNELS*DEBT_W-1:0] debt,
  output logic [CHANNELS-1:0]        lost
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    clkgen_chan #(
      .WIDTH  (WIDTH),
      .DEBT_W (DEBT_W)
    ) u_chan (
      .clock    (clock),
      .reset_n  (reset_n),
      .active   (active[i]),
      .freq     (freq[i*WIDTH +: WIDTH]),
      .fref     (fref[i*WIDTH +: WIDTH]),
      .wait_req (wait_req[i]),
      .clr_lost (clr_lost[i]),
      .hold     (hold[i]),
      .debt     (debt[i*DEBT_W +: DEBT_W]),
      .lost     (lost[i])
    );
  end

endmodule

// File: tb/tb_clkgen_frac.sv
// Bench for clkgen_frac: a two-channel instance (DEBT_W=4) and a one-channel
// instance (DEBT_W=2) checked every cycle against a behavioural scoreboard.
module tb_clkgen_frac;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [1:0]  a_active, a_wait, a_clr, a_hold, a_lost;
  logic [31:0] a_freq, a_fref;
  logic [7:0]  a_debt;
  logic [0:0]  b_active, b_wait, b_clr, b_hold, b_lost;
  logic [15:0] b_freq, b_fref;
  logic [1:0]  b_debt;

  // stimulus per model channel: 0,1 -> dut_a, 2 -> dut_b
  logic act[3], wr[3], cl[3];
  int   fq[3], fr[3];

  int   m_acc[3], m_debt[3];
  bit   m_hold[3], m_lost[3];
  int   sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  assign a_active = {act[1], act[0]};
  assign a_wait   = {wr[1], wr[0]};
  assign a_clr    = {cl[1], cl[0]};
  assign a_freq   = {16'(fq[1]), 16'(fq[0])};
  assign a_fref   = {16'(fr[1]), 16'(fr[0])};
  assign b_active = act[2];
  assign b_wait   = wr[2];
  assign b_clr    = cl[2];
  assign b_freq   = 16'(fq[2]);
  assign b_fref   = 16'(fr[2]);

  always #5 clock = ~clock;

  clkgen_frac #(.CHANNELS(2), .WIDTH(16), .DEBT_W(4)) dut_a (
    .clock(clock), .reset_n(reset_n), .active(a_active), .freq(a_freq),
    .fref(a_fref), .wait_req(a_wait), .clr_lost(a_clr), .hold(a_hold),
    .debt(a_debt), .lost(a_lost)
  );

  clkgen_frac #(.CHANNELS(1), .WIDTH(16), .DEBT_W(2)) dut_b (
    .clock(clock), .reset_n(reset_n), .active(b_active), .freq(b_freq),
    .fref(b_fref), .wait_req(b_wait), .clr_lost(b_clr), .hold(b_hold),
    .debt(b_debt), .lost(b_lost)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  // advance one clock: predict each channel, push, then compare after the edge
  task automatic step();
    int obs;
    for (int c = 0; c < 3; c++) begin
      int mx, ev, iss, d;
      mx = (c == 2) ? 3 : 15;
      if (!reset_n) begin
        m_acc[c] = 0; m_debt[c] = 0; m_hold[c] = 0; m_lost[c] = 0;
      end else if (!act[c]) begin
        m_acc[c] = 0; m_debt[c] = 0; m_hold[c] = 0;
        if (cl[c]) m_lost[c] = 0;
      end else begin
        ev = 0;
        if (fr[c] == 0 || fq[c] == 0) m_acc[c] = 0;
        else if (m_acc[c] >= fr[c]) m_acc[c] = 0;
        else if (fq[c] >= fr[c]) begin ev = 1; m_acc[c] = 0; end
        else begin
          m_acc[c] += fq[c];
          if (m_acc[c] >= fr[c]) begin ev = 1; m_acc[c] -= fr[c]; end
        end
        iss = (!wr[c] && (ev == 1 || m_debt[c] != 0)) ? 1 : 0;
        d = m_debt[c] + ev - iss;
        if (d > mx) begin d = mx; m_lost[c] = 1; end
        else if (cl[c]) m_lost[c] = 0;
        m_debt[c] = d;
        m_hold[c] = (iss == 1);
      end
      sb.push_back(int'(m_hold[c]) * 64 + m_debt[c] * 2 + int'(m_lost[c]));
    end
    @(posedge clock);
    #1;
    obs = int'(a_hold[0]) * 64 + int'(a_debt[3:0]) * 2 + int'(a_lost[0]);
    check_val("sb_ch0", obs, sb.pop_front());
    obs = int'(a_hold[1]) * 64 + int'(a_debt[7:4]) * 2 + int'(a_lost[1]);
    check_val("sb_ch1", obs, sb.pop_front());
    obs = int'(b_hold[0]) * 64 + int'(b_debt) * 2 + int'(b_lost[0]);
    check_val("sb_ch2", obs, sb.pop_front());
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  task automatic clear_inputs();
    for (int c = 0; c < 3; c++) begin
      act[c] = 0; wr[c] = 0; cl[c] = 0; fq[c] = 0; fr[c] = 0;
    end
  endtask

  initial begin
    int cnt0a, cnt0b, cnt1, last, bad_space, maxd, first, cnt, run, found;
    bit in_run;
    clear_inputs();
    do_reset();
    check_val("reset_hold", int'(a_hold), 0);
    check_val("reset_debt", int'(a_debt), 0);
    check_val("reset_lost", int'(a_lost), 0);

    // CPU 35/250 and AY 7/100 side by side
    act[0] = 1; fq[0] = 35; fr[0] = 250;
    act[1] = 1; fq[1] = 7;  fr[1] = 100;
    repeat (250) step();
    cnt0a = 0; cnt0b = 0; cnt1 = 0; last = -1; bad_space = 0; maxd = 0;
    for (int i = 0; i < 500; i++) begin
      step();
      if (a_hold[0]) begin
        if (i < 250) cnt0a++; else cnt0b++;
        if (last >= 0 && (i - last < 7 || i - last > 8)) bad_space++;
        last = i;
      end
      if (a_hold[1]) cnt1++;
      if (int'(a_debt[3:0]) > maxd) maxd = int'(a_debt[3:0]);
    end
    check_val("cpu_win0", cnt0a, 35);
    check_val("cpu_win1", cnt0b, 35);
    check_val("cpu_spacing", bad_space, 0);
    check_val("cpu_debt", maxd, 0);
    check_val("ay_count", cnt1, 35);

    // stalling channel 0 leaves channel 1 untouched
    cnt0a = 0; cnt1 = 0;
    wr[0] = 1;
    for (int i = 0; i < 500; i++) begin
      if (i == 50) wr[0] = 0;
      step();
      if (a_hold[0] && i < 50) cnt0a++;
      if (a_hold[1]) cnt1++;
    end
    check_val("stall_ch0", cnt0a, 0);
    check_val("ay_indep", cnt1, 35);

    // 1/4: first pulse in cycle 5, where cycle 1 is the cycle reset is released
    clear_inputs();
    do_reset();
    act[0] = 1; fq[0] = 1; fr[0] = 4;
    first = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (a_hold[0] && first == 0) first = k + 1;
    end
    check_val("q_first", first, 5);
    act[0] = 0; cnt = 0;
    repeat (3) begin step(); if (a_hold[0]) cnt++; end
    check_val("q_drop", cnt, 0);
    act[0] = 1; first = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (a_hold[0] && first == 0) first = k + 1;
    end
    check_val("q_react", first, 5);

    // 1/2 with 10 stalled cycles, then catch-up
    clear_inputs();
    do_reset();
    act[0] = 1; fq[0] = 1; fr[0] = 2; wr[0] = 1;
    cnt = 0;
    repeat (10) begin step(); if (a_hold[0]) cnt++; end
    check_val("w_pulses", cnt, 0);
    check_val("w_debt", int'(a_debt[3:0]), 5);
    wr[0] = 0; run = 0; in_run = 1;
    repeat (30) begin
      step();
      if (a_hold[0]) begin cnt++; if (in_run) run++; end
      else in_run = 0;
    end
    check_val("w_burst", run, 10);
    check_val("w_total", cnt, 20);
    check_val("w_debt_end", int'(a_debt[3:0]), 0);

    // DEBT_W=2 saturation and lost flag
    clear_inputs();
    do_reset();
    act[2] = 1; fq[2] = 1; fr[2] = 1; wr[2] = 1;
    repeat (5) step();
    check_val("sat_debt", int'(b_debt), 3);
    check_val("sat_lost", int'(b_lost), 1);
    cl[2] = 1;
    step();
    check_val("sat_clr_held", int'(b_lost), 1);
    cl[2] = 0; wr[2] = 0;
    step();
    check_val("sat_release", int'(b_lost), 1);
    cl[2] = 1;
    step();
    check_val("sat_clr", int'(b_lost), 0);
    cl[2] = 0;

    // reprogram 250 -> 10 while the phase sits at 200
    clear_inputs();
    do_reset();
    act[0] = 1; fq[0] = 35; fr[0] = 250;
    found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      step();
      if (m_acc[0] == 200) found = 1;
    end
    check_val("rp_reach", found, 1);
    fr[0] = 10;
    step();
    check_val("rp_nopulse", int'(a_hold[0]), 0);
    cnt = 0;
    repeat (5) begin step(); if (a_hold[0]) cnt++; end
    check_val("rp_clamp", cnt, 5);
    fr[0] = 0; cnt = 0;
    repeat (5) begin step(); if (a_hold[0]) cnt++; end
    check_val("rp_zero", cnt, 0);

    // reset in the middle of catch-up
    clear_inputs();
    do_reset();
    act[0] = 1; fq[0] = 1; fr[0] = 2; wr[0] = 1;
    act[2] = 1; fq[2] = 1; fr[2] = 1; wr[2] = 1;
    repeat (10) step();
    wr[0] = 0; wr[2] = 0;
    repeat (2) step();
    check_val("mid_pre_hold", int'(a_hold[0]), 1);
    check_val("mid_pre_lost", int'(b_lost), 1);
    reset_n = 1'b0;
    step();
    check_val("mid_hold", int'(a_hold[0]), 0);
    check_val("mid_debt", int'(a_debt[3:0]), 0);
    check_val("mid_lost", int'(b_lost), 0);
    reset_n = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
